// File: rtl/data_register.sv
// Parallel-load storage register built from DATASIZE/4 nibble slices sharing clk, rst and enb.
// Optional simulation checks compile in when REGISTER_ASSERT_EN is defined.
module data_register #(
   parameter int unsigned         DATASIZE = 4,
   parameter logic [DATASIZE-1:0] RESETVAL = {DATASIZE{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic [DATASIZE-1:0] data_in,
   output logic [DATASIZE-1:0] data_out
);

   localparam int unsigned NIBBLES = DATASIZE / 4;

   // Every slice loads on the same edge, so the word always updates as a whole.
   for (genvar g = 0; g < NIBBLES; g++) begin : g_nibble
      logic [3:0] nibble_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            nibble_q <= RESETVAL[4*g +: 4];
         end else if (enb) begin
            nibble_q <= data_in[4*g +: 4];
         end
      end

      assign data_out[4*g +: 4] = nibble_q;
   end

`ifdef REGISTER_ASSERT_EN
   initial begin
      if (DATASIZE < 4 || (DATASIZE % 4) != 0) begin
         $error("data_register: DATASIZE=%0d must be a multiple of 4 and >= 4", DATASIZE);
      end
   end

   // Unknown controls or load data would silently corrupt the stored word.
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         if ($isunknown(enb)) begin
            $warning("data_register: enb is X/Z at rising clk");
         end else if (enb === 1'b1 && $isunknown(data_in)) begin
            $warning("data_register: data_in has X/Z bits during load");
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_register.sv
// Scoreboard bench for data_register: a 4-bit and an 8-bit (RESETVAL 8'h3C) instance driven
// by shared controls and compared against a behavioural model of the stored word.
module tb_data_register;

   typedef struct {
      string      name;
      bit         wide;
      logic [7:0] exp;
   } chk_t;

   logic       clk;
   logic       rst;
   logic       enb;
   logic [7:0] data_in;
   logic [3:0] dout4;
   logic [7:0] dout8;

   logic [3:0] model4;
   logic [7:0] model8;

   chk_t sb[$];
   event sb_ev;
   int   checks;
   int   errors;

   data_register #(.DATASIZE(4)) dut4 (
      .clk(clk), .rst(rst), .enb(enb), .data_in(data_in[3:0]), .data_out(dout4)
   );

   data_register #(.DATASIZE(8), .RESETVAL(8'h3C)) dut8 (
      .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .data_out(dout8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the register holds the last word loaded while out of reset, else its reset value.
   task automatic modelReset();
      model4 = 4'h0;
      model8 = 8'h3C;
   endtask

   task automatic checkOutput(input string name);
      chk_t e;
      e.name = name; e.wide = 1'b0; e.exp = {4'h0, model4};
      sb.push_back(e);
      e.wide = 1'b1; e.exp = model8;
      sb.push_back(e);
      ->sb_ev;
   endtask

   // Called just after a falling edge; drives inputs, lets one rising edge pass, checks.
   task automatic applyStimulus(input logic en, input logic [7:0] d, input string name);
      enb     = en;
      data_in = d;
      @(posedge clk);
      if (rst === 1'b1 && en) begin
         model4 = d[3:0];
         model8 = d;
      end
      @(negedge clk);
      checkOutput(name);
   endtask

   // Async reset between edges, observed before any clock edge can act.
   task automatic pulseReset(input logic en, input logic [7:0] d);
      enb     = en;
      data_in = d;
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset");
      @(negedge clk);
      checkOutput("reset_hold");
      rst = 1'b1;
   endtask

   initial begin
      chk_t e;
      logic [7:0] act;
      forever begin
         @(sb_ev);
         while (sb.size() != 0) begin
            e   = sb.pop_front();
            act = e.wide ? dout8 : {4'h0, dout4};
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("[TB] FAIL %s (%0d-bit) at %0t: got %h expected %h",
                        e.name, e.wide ? 8 : 4, $time, act, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      enb     = 1'b0;
      data_in = 8'h00;

      // Reset held for ~50 units while enb and data toggle
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkOutput("reset_immediate");
      enb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data_in = 8'($urandom);
         @(negedge clk);
         checkOutput("reset_held");
      end
      rst = 1'b1;
      enb = 1'b0;

      applyStimulus(1'b1, 8'hAA, "load_A");
      applyStimulus(1'b0, 8'h00, "load_A_hold");
      applyStimulus(1'b1, 8'h55, "reload_5");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'hFF, "hold_5");
      end

      pulseReset(1'b0, 8'hFF);
      applyStimulus(1'b1, 8'hAA, "post_reset_load");
      applyStimulus(1'b0, 8'h33, "post_reset_hold");
      applyStimulus(1'b1, 8'h55, "wide_load_55");
      applyStimulus(1'b1, 8'hC3, "back_to_back_load");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            pulseReset(1'($urandom), 8'($urandom));
         end else begin
            applyStimulus(1'($urandom), 8'($urandom), "random");
         end
      end

      ->sb_ev;
      for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
